// File: rtl/alu_pkg.sv
// Shared constants and the buffered entry payload for the ALU output stage.
package alu_pkg;

  localparam int unsigned RES_W = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD         = 4'd0,
    OP_SUB         = 4'd1,
    OP_MUL         = 4'd2,
    OP_B_AND       = 4'd3,
    OP_B_OR        = 4'd4,
    OP_B_XOR       = 4'd5,
    OP_B_NAND      = 4'd6,
    OP_B_NOR       = 4'd7,
    OP_LSHIFT      = 4'd8,
    OP_RSHIFT      = 4'd9,
    OP_ROT_L       = 4'd10,
    OP_ROT_R       = 4'd11,
    OP_B_XNOR      = 4'd12,
    OP_GREATER     = 4'd13,
    OP_EQUAL       = 4'd14,
    OP_LESSER_THAN = 4'd15
  } opcode_e;

  typedef struct packed {
    logic [RES_W-1:0] y;
    logic [SEL_W-1:0] sel;
    logic             zero;
    logic             carry;
  } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/carry derivation from an ALU result and its opcode.
// Only compiled when ALU_OUT_FLAGS_EN is defined.
`ifdef ALU_OUT_FLAGS_EN
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [RES_W-1:0] y,
  input  logic [SEL_W-1:0] sel,
  output logic             zero,
  output logic             carry
);

  always_comb begin
    zero  = (y == '0);
    carry = 1'b0;
    case (opcode_e'(sel))
      OP_ADD, OP_SUB:    carry = y[8];
      OP_MUL, OP_LSHIFT: carry = |y[RES_W-1:8];
      default:           carry = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/alu_out_stage.sv
// Registered 2-entry skid output stage for the 8-bit ALU with result counter.
// ALU_OUT_FLAGS_EN builds per-entry zero/carry flags; otherwise they read 0.
module alu_out_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_y,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_y,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
  output logic             out_carry,
  output logic [CNT_W-1:0] res_count
);

  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   main_valid;
  logic   skid_valid;
  logic   skid_valid_d;
  logic   in_zero;
  logic   in_carry;
  logic   accept;
  logic   drain;

`ifdef ALU_OUT_FLAGS_EN
  alu_flag_gen u_flag_gen (
    .y     (in_y),
    .sel   (in_sel),
    .zero  (in_zero),
    .carry (in_carry)
  );
`else
  assign in_zero  = 1'b0;
  assign in_carry = 1'b0;
`endif

  assign in_entry = '{y: in_y, sel: in_sel, zero: in_zero, carry: in_carry};
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  // Skid occupancy after this edge; in_ready is its registered complement.
  always_comb begin
    skid_valid_d = skid_valid;
    if (drain && skid_valid)
      skid_valid_d = 1'b0;
    else if (!drain && accept && main_valid)
      skid_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      res_count  <= '0;
    end else begin
      skid_valid <= skid_valid_d;
      in_ready   <= !skid_valid_d;
      if (drain) begin
        res_count <= res_count + CNT_W'(1);
        if (skid_valid)
          main_q <= skid_q;
        else if (accept)
          main_q <= in_entry;
        else
          main_valid <= 1'b0;
      end else if (accept) begin
        if (!main_valid) begin
          main_q     <= in_entry;
          main_valid <= 1'b1;
        end else begin
          skid_q <= in_entry;
        end
      end
    end
  end

  assign out_valid = main_valid;
  assign out_y     = main_q.y;
  assign out_sel   = main_q.sel;
  assign out_zero  = main_q.zero;
  assign out_carry = main_q.carry;

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: vector table, handshake corner cases,
// counter wrap and randomized traffic against a queue-based reference model.
module tb_alu_out_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_y;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_carry;
  logic [15:0] res_count;

  always #5 clk = ~clk;

  alu_out_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
    .out_carry (out_carry),
    .res_count (res_count)
  );

`ifdef ALU_OUT_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] y;
    logic [3:0]  sel;
  } item_t;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  sel;
    logic        z;
    logic        c;
  } vec_t;

  item_t       q[$];
  int unsigned cnt_m;
  bit          rst_m;
  int          passed;
  int          total;

  function automatic logic ref_zero(input logic [15:0] y);
    return FLAGS_ON && (y == 16'd0);
  endfunction

  function automatic logic ref_carry(input logic [15:0] y, input logic [3:0] sel);
    if (!FLAGS_ON) return 1'b0;
    case (sel)
      4'd0, 4'd1: return y[8];
      4'd2, 4'd8: return y > 16'h00FF;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(!rst_m && q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_y", 32'(out_y), 32'(q[0].y));
      chk("out_sel", 32'(out_sel), 32'(q[0].sel));
      chk("out_zero", 32'(out_zero), 32'(ref_zero(q[0].y)));
      chk("out_carry", 32'(out_carry), 32'(ref_carry(q[0].y, q[0].sel)));
    end
    chk("res_count", 32'(res_count), 32'(cnt_m % 65536));
  endtask

  // Drive one cycle at the falling edge, advance the model, check at the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] y, input logic [3:0] s,
                       input logic r, input logic rs);
    bit acc;
    bit drn;
    in_valid  = v;
    in_y      = y;
    in_sel    = s;
    out_ready = r;
    rst       = rs;
    acc = v && !rst_m && (q.size() < 2);
    drn = r && (q.size() > 0);
    if (rs) begin
      q.delete();
      cnt_m = 0;
      rst_m = 1'b1;
    end else begin
      if (drn) begin
        void'(q.pop_front());
        cnt_m = (cnt_m + 1) % 65536;
      end
      if (acc) q.push_back('{y: y, sel: s});
      rst_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b1);
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b1);
  endtask

  vec_t vecs[8];

  initial begin
    passed = 0;
    total  = 0;
    cnt_m  = 0;
    rst_m  = 1'b1;
    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_sel = '0; out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Flag vectors, one per cycle with out_ready held high
    vecs[0] = '{16'h0109, 4'd0, 1'b0, 1'b1};
    vecs[1] = '{16'hFFFE, 4'd1, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 4'd1, 1'b1, 1'b0};
    vecs[3] = '{16'h00FF, 4'd2, 1'b0, 1'b0};
    vecs[4] = '{16'h0100, 4'd2, 1'b0, 1'b1};
    vecs[5] = '{16'h0100, 4'd3, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 4'd8, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 4'd8, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].y, vecs[i].sel, 1'b1, 1'b0);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_y", 32'(out_y), 32'(vecs[i].y));
      chk("vec_zero", 32'(out_zero), 32'(vecs[i].z & FLAGS_ON));
      chk("vec_carry", 32'(out_carry), 32'(vecs[i].c & FLAGS_ON));
      if (i == 1) chk("vec_count_first", 32'(res_count), 32'd1);
    end
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b0);
    chk("vec_count", 32'(res_count), 32'd8);

    // Backpressure: two accepted, third held until the skid drains
    do_reset();
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 16'h00A1, 4'd4, 1'b0, 1'b0);
    cycle(1'b1, 16'h00B2, 4'd5, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h00C3, 4'd6, 1'b0, 1'b0);
    chk("bp_stable_y", 32'(out_y), 32'h00A1);
    cycle(1'b1, 16'h00C3, 4'd6, 1'b1, 1'b0);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    chk("bp_second_y", 32'(out_y), 32'h00B2);
    cycle(1'b1, 16'h00C3, 4'd6, 1'b1, 1'b0);
    chk("bp_third_y", 32'(out_y), 32'h00C3);
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b0);
    chk("bp_count", 32'(res_count), 32'd3);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with both slots full
    cycle(1'b1, 16'h1111, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 4'd1, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h3333, 4'd2, 1'b1, 1'b1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(res_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b0);
    chk("midrst_release", 32'(in_ready), 32'd1);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
    end

    // Counter wrap: 65537 results streamed at full throughput
    do_reset();
    cycle(1'b0, 16'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65537; i++) begin
      cycle(1'b1, 16'(i), 4'(i), 1'b1, 1'b0);
    end
    cycle(1'b0, 16'd0, 4'd0, 1'b1, 1'b0);
    chk("wrap_count", 32'(res_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
